// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// -----------------------------------------------------------------------------
// Shares one single-ported, handshaked unified memory between the fetch-stage
// instruction port and the memory-stage data port of the pipelined MIPS core.
// Each access runs IDLE -> IBUSY/DBUSY -> RESP -> IDLE. While any requester is
// waiting, the stall output is high.
//
// Ports
//   clk, reset       single rising-edge clock, synchronous active-high reset
//   ireq/iaddr       fetch request and address (held until iready)
//   irdata/iready    fetched word, one-cycle completion pulse
//   dreq/dwe/daddr/dwdata
//                    data request, write enable, address, store data
//   drdata/dready    load data, one-cycle completion pulse
//   memreq/memwe/memaddr/memwdata
//                    memory request (held until memack) and access fields
//   memrdata/memack  memory read data, one-cycle completion from memory
//   stall            combinational pipeline stall
//
// Build option
//   MEM_ARB_RR_EN    when defined, a tie in IDLE goes to the side that was not
//                    granted last (D wins the first tie after reset). When
//                    undefined, the data side always has priority.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq,
    input  logic [AWIDTH-1:0] iaddr,
    output logic [WIDTH-1:0]  irdata,
    output logic              iready,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [AWIDTH-1:0] daddr,
    input  logic [WIDTH-1:0]  dwdata,
    output logic [WIDTH-1:0]  drdata,
    output logic              dready,
    output logic              memreq,
    output logic              memwe,
    output logic [AWIDTH-1:0] memaddr,
    output logic [WIDTH-1:0]  memwdata,
    input  logic [WIDTH-1:0]  memrdata,
    input  logic              memack,
    output logic              stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic              memreq_reg;
    logic              memwe_reg;
    logic [AWIDTH-1:0] memaddr_reg;
    logic [WIDTH-1:0]  memwdata_reg;
    logic [WIDTH-1:0]  irdata_reg;
    logic [WIDTH-1:0]  drdata_reg;
    logic              iready_reg;
    logic              dready_reg;

    logic grant_d;
    logic grant_i;

`ifdef MEM_ARB_RR_EN
    // 1 = the most recent grant went to the instruction side. Resetting to 1
    // makes the data side win the first tie.
    logic last_i_reg;
`endif

    // Grant decision; only meaningful in IDLE. RESP deliberately never grants
    // because the requester's req still refers to the access just completed.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_reg == IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (dreq && ireq) begin
                grant_d = last_i_reg;
                grant_i = ~last_i_reg;
            end else begin
                grant_d = dreq;
                grant_i = ireq;
            end
`else
            // Data side is the older instruction, so it always goes first.
            grant_d = dreq;
            grant_i = ireq & ~dreq;
`endif
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_i_reg <= 1'b1;
        end else if (grant_i) begin
            last_i_reg <= 1'b1;
        end else if (grant_d) begin
            last_i_reg <= 1'b0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. memack outside the busy states is simply ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next = DBUSY;
                end else if (grant_i) begin
                    state_next = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (memack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered memory-side fields and requester responses. The mem* fields
    // are only written on a grant, so they stay stable for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            memreq_reg   <= 1'b0;
            memwe_reg    <= 1'b0;
            memaddr_reg  <= '0;
            memwdata_reg <= '0;
            irdata_reg   <= '0;
            drdata_reg   <= '0;
            iready_reg   <= 1'b0;
            dready_reg   <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses.
            iready_reg <= 1'b0;
            dready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        memaddr_reg  <= daddr;
                        memwdata_reg <= dwdata;
                        memwe_reg    <= dwe;
                        memreq_reg   <= 1'b1;
                    end else if (grant_i) begin
                        memaddr_reg  <= iaddr;
                        memwdata_reg <= '0;
                        memwe_reg    <= 1'b0;
                        memreq_reg   <= 1'b1;
                    end
                end
                IBUSY: begin
                    if (memack) begin
                        irdata_reg <= memrdata;
                        iready_reg <= 1'b1;
                        memreq_reg <= 1'b0;
                    end
                end
                DBUSY: begin
                    // Stores also capture memrdata; the value is don't-care.
                    if (memack) begin
                        drdata_reg <= memrdata;
                        dready_reg <= 1'b1;
                        memreq_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign memreq   = memreq_reg;
    assign memwe    = memwe_reg;
    assign memaddr  = memaddr_reg;
    assign memwdata = memwdata_reg;
    assign irdata   = irdata_reg;
    assign drdata   = drdata_reg;
    assign iready   = iready_reg;
    assign dready   = dready_reg;

    // Combinational so the pipeline releases in the same cycle the ready
    // pulse appears.
    assign stall = (ireq & ~iready) | (dreq & ~dready);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter: each phase queues requester jobs plus the
// grants/completions it expects in arbitration order. A memory model answers
// memreq after a programmable latency and can inject spurious memack pulses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwe;
    logic        iready, dready, memreq, memwe, memack, stall;
    logic [31:0] iaddr, irdata, daddr, dwdata, drdata;
    logic [31:0] memaddr, memwdata, memrdata;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .AWIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .ireq     (ireq),
        .iaddr    (iaddr),
        .irdata   (irdata),
        .iready   (iready),
        .dreq     (dreq),
        .dwe      (dwe),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .drdata   (drdata),
        .dready   (dready),
        .memreq   (memreq),
        .memwe    (memwe),
        .memaddr  (memaddr),
        .memwdata (memwdata),
        .memrdata (memrdata),
        .memack   (memack),
        .stall    (stall)
    );

    // side: 1 = data port, 0 = instruction port.
    typedef struct packed {
        logic        side;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        chk_gap;
    } txn_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } djob_t;

    txn_t        grant_q[$];
    txn_t        done_q[$];
    logic [31:0] ijob_q[$];
    djob_t       djob_q[$];
    logic [31:0] mem [logic [31:0]];

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    bit spur     = 1'b0;
    int igap     = 0;
    int dgap     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(input logic side, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic chk_gap);
        grant_q.push_back('{side, we, addr, wdata, rdata, chk_gap});
        done_q.push_back('{side, we, addr, wdata, rdata, chk_gap});
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((done_q.size() != 0 || grant_q.size() != 0 ||
                ijob_q.size() != 0 || djob_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < budget, 1);
        if (n >= budget) begin
            done_q.delete();
            grant_q.delete();
            ijob_q.delete();
            djob_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Memory model: acks `lat` cycles after memreq rises (0 = same cycle).
    initial begin
        int cnt;
        bit acked;
        cnt = 0;
        acked = 1'b0;
        memack = 1'b0;
        memrdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (memreq && !acked) begin
                if (cnt == lat) begin
                    memack = 1'b1;
                    acked = 1'b1;
                    if (memwe) mem[memaddr] = memwdata;
                    memrdata = mem.exists(memaddr) ? mem[memaddr] : ~memaddr;
                end else begin
                    memack = 1'b0;
                    cnt++;
                end
            end else begin
                memack = spur && !memreq;
                if (memack) memrdata = 32'hBAD0_BAD0;
                if (!memreq) begin
                    acked = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    // Instruction requester: holds ireq until iready, then stays idle for
    // igap cycles before presenting the next job.
    initial begin
        int wait_i;
        wait_i = 0;
        ireq = 1'b0;
        iaddr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ireq = 1'b0;
                wait_i = 0;
                continue;
            end
            if (ireq && iready) begin
                void'(ijob_q.pop_front());
                ireq = 1'b0;
                wait_i = igap;
            end
            if (wait_i > 0) begin
                wait_i--;
                continue;
            end
            if (!ireq && ijob_q.size() > 0) begin
                ireq = 1'b1;
                iaddr = ijob_q[0];
            end
        end
    end

    // Data requester, same behaviour with dgap.
    initial begin
        int wait_d;
        wait_d = 0;
        dreq = 1'b0;
        dwe = 1'b0;
        daddr = '0;
        dwdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dreq = 1'b0;
                wait_d = 0;
                continue;
            end
            if (dreq && dready) begin
                void'(djob_q.pop_front());
                dreq = 1'b0;
                wait_d = dgap;
            end
            if (wait_d > 0) begin
                wait_d--;
                continue;
            end
            if (!dreq && djob_q.size() > 0) begin
                dreq = 1'b1;
                dwe = djob_q[0].we;
                daddr = djob_q[0].addr;
                dwdata = djob_q[0].wdata;
            end
        end
    end

    // Monitor: sampled 1 ns after each rising edge.
    initial begin
        int   cyc;
        int   rise_cyc;
        bit   memreq_q;
        txn_t cur;
        txn_t d;
        cyc = 0;
        rise_cyc = 0;
        memreq_q = 1'b0;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                memreq_q = 1'b0;
                continue;
            end
            if (memreq && !memreq_q) begin
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", 1, 0);
                end else begin
                    cur = grant_q.pop_front();
                    check("grant_addr", memaddr, cur.addr);
                    check("grant_we", memwe, cur.we);
                    check("grant_wdata", memwdata, cur.wdata);
                    if (cur.chk_gap) check("grant_spacing", cyc - rise_cyc, 3);
                end
                rise_cyc = cyc;
            end else if (memreq) begin
                check("hold_addr", memaddr, cur.addr);
                check("hold_we", memwe, cur.we);
                check("hold_wdata", memwdata, cur.wdata);
            end
            if (memreq && !iready && !dready) check("stall_waiting", stall, 1);
            if (iready || dready) begin
                check("ready_onehot", iready & dready, 0);
                if (done_q.size() == 0) begin
                    check("ready_unexpected", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    check("ready_side", dready, d.side);
                    check("ready_latency", cyc - rise_cyc, lat + 1);
                    if (!d.we) check("rdata", d.side ? drdata : irdata, d.rdata);
                    if (iready && !dreq) check("stall_in_iready", stall, 0);
                    if (dready && !ireq) check("stall_in_dready", stall, 0);
                    $display("txn %s addr=0x%08h we=%0d data=0x%08h cyc=%0d",
                             d.side ? "D" : "I", d.addr, d.we,
                             d.side ? drdata : irdata, cyc);
                end
            end
            memreq_q = memreq;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog no summary reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        mem[32'h4] = 32'h2002_0005;
        mem[32'h8] = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            mem[32'h100 + 4 * k] = 32'hA0 + k;
            mem[32'h200 + 4 * k] = 32'hB0 + k;
            mem[32'h300 + 4 * k] = 32'hC0 + k;
        end
        mem[32'h400] = 32'hD0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_memreq", memreq, 0);
        check("rst_memwe", memwe, 0);
        check("rst_memaddr", memaddr, 0);
        check("rst_memwdata", memwdata, 0);
        check("rst_iready", iready, 0);
        check("rst_dready", dready, 0);
        check("rst_irdata", irdata, 0);
        check("rst_drdata", drdata, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;
        @(negedge clk);

        // Lone fetch, memory answers 3 cycles after memreq.
        lat = 3;
        @(posedge clk);
        expect_txn(0, 0, 32'h4, 0, 32'h2002_0005, 0);
        ijob_q.push_back(32'h4);
        wait_done("timeout_fetch", 100);
        check("irdata_after_fetch", irdata, 32'h2002_0005);

        // Store then load at the same address.
        lat = 1;
        @(posedge clk);
        expect_txn(1, 1, 32'h54, 32'h7, 0, 0);
        expect_txn(1, 0, 32'h54, 0, 32'h7, 0);
        djob_q.push_back('{1'b1, 32'h54, 32'h7});
        djob_q.push_back('{1'b0, 32'h54, 32'h0});
        wait_done("timeout_store_load", 100);
        check("drdata_after_load", drdata, 32'h7);
        check("irdata_untouched", irdata, 32'h2002_0005);

        // Spurious memack while idle, then across a fetch (hits IDLE and RESP).
        spur = 1'b1;
        repeat (6) @(negedge clk);
        check("spur_irdata", irdata, 32'h2002_0005);
        check("spur_drdata", drdata, 32'h7);
        lat = 2;
        @(posedge clk);
        expect_txn(0, 0, 32'h8, 0, 32'h1111_2222, 0);
        ijob_q.push_back(32'h8);
        wait_done("timeout_spur_fetch", 100);
        spur = 1'b0;
        check("spur_fetch_irdata", irdata, 32'h1111_2222);
        check("spur_fetch_drdata", drdata, 32'h7);

        // Reset while DBUSY abandons the request.
        lat = 40;
        @(posedge clk);
        expect_txn(1, 0, 32'h60, 0, 0, 0);
        djob_q.push_back('{1'b0, 32'h60, 32'h0});
        for (int n = 0; n < 20 && !memreq; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("abandon_memreq_up", memreq, 1);
        reset = 1'b1;
        djob_q.delete();
        @(negedge clk);
        check("abandon_memreq", memreq, 0);
        check("abandon_dready", dready, 0);
        check("abandon_drdata", drdata, 0);
        check("abandon_memaddr", memaddr, 0);
        @(negedge clk);
        reset = 1'b0;
        done_q.delete();
        grant_q.delete();
        lat = 0;
        @(posedge clk);
        expect_txn(0, 0, 32'h4, 0, 32'h2002_0005, 0);
        ijob_q.push_back(32'h4);
        wait_done("timeout_post_reset", 100);

        // Both sides busy, 0-latency memory, requesters pause after ready.
        igap = 2;
        dgap = 2;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            djob_q.push_back('{1'b0, 32'h100 + 4 * k, 32'h0});
            ijob_q.push_back(32'h200 + 4 * k);
            expect_txn(1, 0, 32'h100 + 4 * k, 0, 32'hA0 + k, k != 0);
            expect_txn(0, 0, 32'h200 + 4 * k, 0, 32'hB0 + k, 1);
        end
        wait_done("timeout_alternate", 300);

        // Both sides held continuously.
        igap = 0;
        dgap = 0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) djob_q.push_back('{1'b0, 32'h300 + 4 * k, 32'h0});
        ijob_q.push_back(32'h400);
`ifdef MEM_ARB_RR_EN
        expect_txn(1, 0, 32'h300, 0, 32'hC0, 0);
        expect_txn(0, 0, 32'h400, 0, 32'hD0, 1);
        expect_txn(1, 0, 32'h304, 0, 32'hC1, 1);
        expect_txn(1, 0, 32'h308, 0, 32'hC2, 1);
`else
        expect_txn(1, 0, 32'h300, 0, 32'hC0, 0);
        expect_txn(1, 0, 32'h304, 0, 32'hC1, 1);
        expect_txn(1, 0, 32'h308, 0, 32'hC2, 1);
        expect_txn(0, 0, 32'h400, 0, 32'hD0, 1);
`endif
        wait_done("timeout_held", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
